// File: rtl/circ_pkg.sv
// Shared constants for the 8-entry circular buffer and its read-side drain consumer.
package circ_pkg;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 8;
  localparam int SUM_W  = 7;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/circ_drain_accum.sv
// Drains a requested number of words from the circular buffer read port,
// forwarding each word as a one-cycle strobe and accumulating their total.
module circ_drain_accum #(
  parameter int DATA_W = circ_pkg::DATA_W,
  parameter int CNT_W  = circ_pkg::CNT_W,
  parameter int SUM_W  = circ_pkg::SUM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              empty,
  input  logic [DATA_W-1:0] dout,
  output logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done
);

  import circ_pkg::drain_state_t;
  import circ_pkg::IDLE;
  import circ_pkg::READ;
  import circ_pkg::DRAIN;
  import circ_pkg::DONE;

  drain_state_t      state_r;
  drain_state_t      state_nxt_s;
  logic [CNT_W-1:0]  remaining_r;
  logic [CNT_W-1:0]  issued_r;
  logic [CNT_W-1:0]  issued_inc_s;
  logic              rd_s;
  logic              rd_q_r;
  logic              accept_s;
  logic              last_issue_s;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic [SUM_W-1:0]  sum_r;
  logic              busy_r;
  logic              done_r;

  // Read request is combinational so an empty flag seen this cycle blocks the read at once.
  assign rd_s         = (state_r == READ) && !empty && (issued_r < remaining_r);
  assign issued_inc_s = issued_r + CNT_W'(1'b1);
  assign last_issue_s = rd_s && (issued_inc_s == remaining_r);
  assign accept_s     = (state_r == IDLE) && start;

  // Next-state selection for the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (count == {CNT_W{1'b0}}) ? DONE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (last_issue_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (rd_q_r) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus the registered busy/done flags derived from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Burst bookkeeping: requested length and reads issued so far.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining_r <= {CNT_W{1'b0}};
      issued_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      remaining_r <= count;
      issued_r    <= {CNT_W{1'b0}};
    end else if (rd_s) begin
      issued_r    <= issued_inc_s;
    end else begin
      issued_r    <= issued_r;
    end
  end

  // Buffer data lags the read by one edge, so capture is keyed on the delayed read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q_r       <= 1'b0;
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      sum_r        <= {SUM_W{1'b0}};
    end else begin
      rd_q_r <= rd_s;
      if (rd_q_r) begin
        data_out_r   <= dout;
        data_valid_r <= 1'b1;
        sum_r        <= sum_r + {{(SUM_W-DATA_W){1'b0}}, dout};
      end else if (accept_s) begin
        data_valid_r <= 1'b0;
        sum_r        <= {SUM_W{1'b0}};
      end else begin
        data_valid_r <= 1'b0;
      end
    end
  end

  assign rd         = rd_s;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign sum        = sum_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
